mem_writeback: RTL
==================

Name: mem_writeback

Overview:
- Memory-access and writeback stage of the pipeline. It sits after execute and is the producer side of the decode stage's register-file write port (reg_write_data / reg_write_enable / reg_write_addr).
- It takes ALU results, performs loads and stores over a req/ack data-memory bus with variable latency, and aligns load data.
- It drives one registered writeback per retired instruction and stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in MEM_WAIT without mem_ack before the access is abandoned and bus_error is set.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  execute presents an instruction this cycle
- alu_result  in  32  ALU result; effective address for loads and stores
- rs2_data  in  32  store data
- next_pc_in  in  32  pc+4, written to rd for jumps
- jump_in  in  1  instruction is JAL/JALR
- res_src_in  in  1  0 = ALU result, 1 = load data
- mem_write_enable_in  in  1  store
- funct3_in  in  3  load/store size and sign
- rd_write_enable_in  in  1  instruction writes rd
- rd_write_addr_in  in  5  destination register
- stall  out  1  upstream must hold its inputs and not advance
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, {alu_result[31:2],2'b00}
- mem_wdata  out  32  byte-lane-placed store data
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- reg_write_enable  out  1  regfile write strobe
- reg_write_addr  out  5  regfile write address
- reg_write_data  out  32  regfile write data
- misalign_error  out  1  sticky; set on misaligned load or store
- bus_error  out  1  sticky; set on timeout

Behaviour:
- Reset: one clock domain; rst_n is asynchronous and active-low. Every output and the state register clear to 0 immediately, state = IDLE. Reset during MEM_WAIT drops mem_req at once; the pending writeback is discarded.
- stall = (state == MEM_WAIT). It is combinational from state. An instruction is consumed only when valid_in=1 and state=IDLE.
- IDLE, non-memory instruction (res_src_in=0 and mem_write_enable_in=0):
  - Accepted at edge N.
  - reg_write_enable=1 for exactly the cycle after N.
  - reg_write_data = next_pc_in if jump_in, else alu_result.
- Write suppression: reg_write_enable is forced to 0 when rd_write_addr_in=0 or rd_write_enable_in=0. reg_write_addr and reg_write_data still update.
- IDLE, load or store:
  - Misalignment check first: halfword with addr[0]=1, or word with addr[1:0]≠0. If misaligned: set misalign_error, no bus request, no writeback, stay in IDLE.
  - Otherwise latch addr, size, sign, rd and rdata lane. Set mem_req=1 from the next cycle and go to MEM_WAIT with the timeout counter at 0.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay stable.
  - On mem_ack: mem_req=0 next cycle, state returns to IDLE. For a load, reg_write_enable pulses one cycle with the aligned data in the cycle after the ack. For a store, no writeback.
  - Counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES: set bus_error, mem_req=0, no writeback, return to IDLE.
  - Ack and timeout in the same cycle: the ack wins.
- Ack while in IDLE: ignored.
- Stores:
  - SB (funct3 000): wdata = rs2[7:0] replicated to all 4 lanes; wstrb = 0001 << addr[1:0].
  - SH (001): rs2[15:0] replicated to both halves; wstrb = 0011 << addr[1:0].
  - SW (010): rs2 unchanged; wstrb = 1111.
- Loads: shifted = mem_rdata >> (8*addr[1:0]).
  - LB (000): sign-extend shifted[7:0].
  - LH (001): sign-extend shifted[15:0].
  - LW (010): shifted, all 32 bits.
  - LBU (100): zero-extend shifted[7:0].
  - LHU (101): zero-extend shifted[15:0].
  - Other funct3 values are treated as LW/SW.
- Sticky error flags clear only on reset.
- Load-use latency: accept at N, mem_req from N+1, ack at M ≥ N+1, writeback at M+1, next accept at M+1.

Decomposition:
- Shared constants file:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State encoding: IDLE = 0, MEM_WAIT = 1.
  - RES_SRC_ALU / RES_SRC_MEM.
- One combinational sub-module, load_store_align: addr[1:0], funct3, rs2, rdata in; wdata, wstrb, load data and misaligned flag out. It is reused by any future cache path.

Test Plan:
- ADD result 0x0000_1234 to rd=5, valid one cycle → next cycle reg_write_enable=1, addr=5, data=0x0000_1234; stall never asserted.
- JAL, rd=1, next_pc_in=0x0000_0104 → writeback data 0x0000_0104. Same instruction with rd=0 → reg_write_enable stays 0.
- LB at addr 0x103, ack after 3 cycles with rdata=0x80FF_0000:
  - mem_addr=0x100; stall high for 4 cycles.
  - Writeback 0xFFFF_FF80 in the cycle after ack.
  - Repeat as LBU → 0x0000_0080.
- SH at addr 0x202, rs2=0xDEAD_BEEF → mem_we=1, wstrb=1100, wdata=0xBEEF_BEEF; no writeback after ack.
- LW at 0x301 → misalign_error=1, mem_req never rises. LW at 0x300 with no ack → bus_error=1 after 255 cycles, mem_req drops, stall releases.
- Assert rst_n=0 mid MEM_WAIT → mem_req, stall and reg_write_enable all go to 0 immediately; no writeback occurs after release.

Source files
------------

// File: rtl/mem_writeback_pkg.sv
// Shared encodings for the memory-access / writeback stage.
package mem_writeback_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic RES_SRC_ALU = 1'b0;
  localparam logic RES_SRC_MEM = 1'b1;

  // Context of the outstanding access, needed to finish it on ack
  typedef struct packed {
    logic [1:0] addr_lo;
    logic [2:0] funct3;
    logic       is_store;
    logic       rd_we;
    logic [4:0] rd;
  } pend_t;

endpackage

// File: rtl/mem_writeback_load_store_align.sv
// Byte-lane placement for stores, alignment/extension for loads, misalign detection.
module mem_writeback_load_store_align
  import mem_writeback_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;
  logic        is_byte;
  logic        is_half;

  always_comb begin
    wdata_o     = rs2_i;
    wstrb_o     = 4'b1111;
    load_data_o = 32'h0;
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    is_byte     = 1'b0;
    is_half     = 1'b0;

    if (is_store_i) begin
      case (funct3_i)
        F3_SB: begin
          wdata_o = {4{rs2_i[7:0]}};
          wstrb_o = 4'b0001 << addr_lo_i;
          is_byte = 1'b1;
        end
        F3_SH: begin
          wdata_o = {2{rs2_i[15:0]}};
          wstrb_o = 4'b0011 << addr_lo_i;
          is_half = 1'b1;
        end
        default: ;
      endcase
    end

    // Unlisted load encodings fall through to a full word
    case (funct3_i)
      F3_LB: begin
        load_data_o = {{24{shifted[7]}}, shifted[7:0]};
        is_byte     = is_byte | ~is_store_i;
      end
      F3_LH: begin
        load_data_o = {{16{shifted[15]}}, shifted[15:0]};
        is_half     = is_half | ~is_store_i;
      end
      F3_LBU: begin
        load_data_o = {24'h0, shifted[7:0]};
        is_byte     = is_byte | ~is_store_i;
      end
      F3_LHU: begin
        load_data_o = {16'h0, shifted[15:0]};
        is_half     = is_half | ~is_store_i;
      end
      default: load_data_o = shifted;
    endcase

    misaligned_o = (is_half && addr_lo_i[0]) ||
                   (!is_byte && !is_half && (addr_lo_i != 2'b00));
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory-access and writeback stage: req/ack data bus with timeout, one registered
// regfile write per retired instruction, stall while an access is outstanding.
module mem_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [31:0] next_pc_in,
  input  logic        jump_in,
  input  logic        res_src_in,
  input  logic        mem_write_enable_in,
  input  logic [2:0]  funct3_in,
  input  logic        rd_write_enable_in,
  input  logic [4:0]  rd_write_addr_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_data,
  output logic        misalign_error,
  output logic        bus_error
);
  import mem_writeback_pkg::*;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  pend_t            pend_q, pend_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             rwe_q, rwe_d;
  logic [4:0]       raddr_q, raddr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d, berr_q, berr_d;

  logic             waiting;
  logic             is_mem_op;
  logic [1:0]       al_lo;
  logic [2:0]       al_f3;
  logic             al_st;
  logic [31:0]      al_wdata, al_load;
  logic [3:0]       al_wstrb;
  logic             al_mis;

  assign waiting   = (state_q == ST_MEM_WAIT);
  assign stall     = waiting;
  assign is_mem_op = (res_src_in == RES_SRC_MEM) || mem_write_enable_in;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Aligner sees the new instruction in IDLE and the latched access while waiting
  assign al_lo = waiting ? pend_q.addr_lo  : alu_result[1:0];
  assign al_f3 = waiting ? pend_q.funct3   : funct3_in;
  assign al_st = waiting ? pend_q.is_store : mem_write_enable_in;

  mem_writeback_load_store_align u_align (
    .addr_lo_i    (al_lo),
    .funct3_i     (al_f3),
    .is_store_i   (al_st),
    .rs2_i        (rs2_data),
    .rdata_i      (mem_rdata),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rwe_d   = 1'b0;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    berr_d  = berr_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in && is_mem_op) begin
          if (al_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d         = ST_MEM_WAIT;
            cnt_d           = '0;
            req_d           = 1'b1;
            we_d            = mem_write_enable_in;
            addr_d          = {alu_result[31:2], 2'b00};
            wdata_d         = al_wdata;
            wstrb_d         = mem_write_enable_in ? al_wstrb : 4'b0000;
            pend_d.addr_lo  = alu_result[1:0];
            pend_d.funct3   = funct3_in;
            pend_d.is_store = mem_write_enable_in;
            pend_d.rd_we    = rd_write_enable_in;
            pend_d.rd       = rd_write_addr_in;
          end
        end else if (valid_in) begin
          rwe_d   = rd_write_enable_in && (rd_write_addr_in != 5'd0);
          raddr_d = rd_write_addr_in;
          rdata_d = jump_in ? next_pc_in : alu_result;
        end
      end
      ST_MEM_WAIT: begin
        // Ack takes priority over a timeout on the same cycle
        if (mem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          if (!pend_q.is_store) begin
            rwe_d   = pend_q.rd_we && (pend_q.rd != 5'd0);
            raddr_d = pend_q.rd;
            rdata_d = al_load;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rwe_q   <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rwe_q   <= rwe_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign mem_wstrb        = wstrb_q;
  assign reg_write_enable = rwe_q;
  assign reg_write_addr   = raddr_q;
  assign reg_write_data   = rdata_q;
  assign misalign_error   = mis_q;
  assign bus_error        = berr_q;

endmodule
